multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the 8-bit MIPS-style datapath. It shares one memory port and one ALU across

---
 rtl/multicycle_ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle control sequencer for the 8-bit MIPS-style datapath
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       halted,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, HALT, TRAP
  } state_t;

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       in_wait;
  logic       timed_out;
  state_t     boundary_next;

  assign in_wait       = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timed_out     = in_wait && !mem_ready && (wait_cnt == 4'(TIMEOUT));
  assign boundary_next = halt_req ? HALT : FETCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      wait_cnt   <= 4'd0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_next;
      // counter only runs while parked in a memory wait; any exit clears it
      if (in_wait && !mem_ready && (state_next == state))
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= 4'd0;
      if ((state != TRAP) && (state_next == TRAP))
        trap_cause <= (state == DECODE) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (mem_ready)      state_next = DECODE;
        else if (timed_out) state_next = TRAP;
      end
      DECODE: begin
        case (opcode)
          6'b000000:                       state_next = EXEC_R;
          6'b001000, 6'b001001, 6'b001010: state_next = EXEC_I;
          6'b100011, 6'b101011:            state_next = MEM_ADDR;
          6'b000100:                       state_next = BRANCH;
          6'b000010:                       state_next = JUMP;
          default:                         state_next = TRAP;
        endcase
      end
      EXEC_R:   state_next = WB_R;
      EXEC_I:   state_next = WB_I;
      MEM_ADDR: state_next = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ready)      state_next = MEM_WB;
        else if (timed_out) state_next = TRAP;
      end
      MEM_WR: begin
        if (mem_ready)      state_next = boundary_next;
        else if (timed_out) state_next = TRAP;
      end
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: state_next = boundary_next;
      HALT:     state_next = halt_req ? HALT : FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    trap        = 1'b0;
    instr_done  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == 6'b001001) ? 2'b01 : 2'b00;
      end
      WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCWrite     = zero;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      HALT:    halted = 1'b1;
      TRAP:    trap   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       halt_req = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource, trap_cause;
  logic       halted, trap, instr_done;

  multicycle_ctrl_fsm #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .halt_req(halt_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_ld, pcw_cond, iord, irw, mem_rd, mem_wr, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       hlt, trp;
    logic [1:0] tc;
    logic       done;
  } sv_t;

  typedef struct {
    sv_t   v;
    string tag;
  } exp_t;

  typedef enum int {
    S_FETCH, S_DECODE, S_EXR, S_WBR, S_EXI, S_WBI, S_MADDR, S_MRD,
    S_MWB, S_MWR, S_BR, S_J, S_HALT, S_TRAP
  } step_t;

  exp_t exp_q[$];
  int   ret_q[$];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   run_cycles = 0;
  sv_t  act;

  // effective PC load as the datapath sees it, independent of how the strobes split it
  assign act = {PCWrite | (PCWriteCond & zero), PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, trap,
                trap_cause, instr_done};

  function automatic sv_t exp_for(step_t s, logic [5:0] op, logic rdy, logic z, logic [1:0] tc);
    sv_t e = '0;
    case (s)
      S_FETCH:  begin e.mem_rd = 1; e.asb = 2'b01; e.irw = rdy; e.pc_ld = rdy; end
      S_DECODE: e.asb = 2'b11;
      S_EXR:    begin e.asa = 1; e.aop = 2'b10; end
      S_WBR:    begin e.rdst = 1; e.rw = 1; e.done = 1; end
      S_EXI:    begin e.asa = 1; e.asb = 2'b10; e.aop = (op == 6'b001001) ? 2'b01 : 2'b00; end
      S_WBI:    begin e.rw = 1; e.done = 1; end
      S_MADDR:  begin e.asa = 1; e.asb = 2'b10; end
      S_MRD:    begin e.iord = 1; e.mem_rd = 1; end
      S_MWB:    begin e.m2r = 1; e.rw = 1; e.done = 1; end
      S_MWR:    begin e.iord = 1; e.mem_wr = 1; e.done = rdy; end
      S_BR:     begin e.asa = 1; e.aop = 2'b01; e.pcw_cond = 1; e.psrc = 2'b01; e.pc_ld = z; e.done = 1; end
      S_J:      begin e.pc_ld = 1; e.psrc = 2'b10; e.done = 1; end
      S_HALT:   e.hlt = 1;
      S_TRAP:   begin e.trp = 1; e.tc = tc; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      run_cycles = 0;
    end else begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_queue_empty act=%h required=an expected entry", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.v) begin
          errors++;
          $display("FAIL strobes_%s act=%h required=%h", e.tag, act, e.v);
        end
      end
      if (!halted) run_cycles++;
      if (instr_done) begin
        checks++;
        if (ret_q.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected act=%0d cycles required=no retirement", run_cycles);
        end else begin
          int r;
          r = ret_q.pop_front();
          if (r != run_cycles) begin
            errors++;
            $display("FAIL retire_latency act=%0d required=%0d", run_cycles, r);
          end
        end
        run_cycles = 0;
      end
    end
  end

  task automatic cyc(input sv_t e, input string tag);
    exp_t x;
    x.v = e;
    x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    halt_req  = 1'($urandom);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    ret_q.delete();
  endtask

  task automatic do_trap(input logic [1:0] tc);
    repeat (3) begin
      rnd();
      opcode = 6'($urandom);
      cyc(exp_for(S_TRAP, opcode, mem_ready, zero, tc), "trap");
    end
    do_reset();
  endtask

  // lat = number of mem_ready-low cycles before the ready cycle; 16 lows end in a trap
  task automatic do_wait(input step_t s, input int lat, input bit hb, input int rc, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      if (i == 16) begin
        trapped = 1'b1;
        return;
      end
      mem_ready = (i == lat);
      zero      = 1'($urandom);
      halt_req  = (s == S_MWR && i == lat) ? hb : 1'($urandom);
      if (s == S_MWR && i == lat) ret_q.push_back(rc);
      cyc(exp_for(s, opcode, mem_ready, zero, 2'b00), s.name());
    end
  endtask

  task automatic finish(input step_t s, input bit hb, input int rc, input logic z);
    mem_ready = 1'($urandom);
    zero      = z;
    halt_req  = hb;
    ret_q.push_back(rc);
    cyc(exp_for(s, opcode, mem_ready, zero, 2'b00), s.name());
  endtask

  // nh < 0: no halt; otherwise halt_req is held nh extra cycles in HALT
  task automatic run_instr(input logic [5:0] op, input int lf, input int lm, input bit z, input int nh);
    bit tr;
    bit hb;
    int rc;
    hb = (nh >= 0);
    rc = lf + 2;
    case (op)
      6'h00, 6'h08, 6'h09, 6'h0A: rc += 2;
      6'h23:                      rc += lm + 3;
      6'h2B:                      rc += lm + 2;
      default:                    rc += 1;
    endcase
    opcode = 6'($urandom);
    do_wait(S_FETCH, lf, 1'b0, 0, tr);
    if (tr) begin
      do_trap(2'b10);
      return;
    end
    opcode = op;
    rnd();
    cyc(exp_for(S_DECODE, opcode, mem_ready, zero, 2'b00), "S_DECODE");
    case (op)
      6'h00: begin rnd(); cyc(exp_for(S_EXR, op, mem_ready, zero, 2'b00), "S_EXR");
                   finish(S_WBR, hb, rc, 1'($urandom)); end
      6'h08, 6'h09, 6'h0A: begin rnd(); cyc(exp_for(S_EXI, op, mem_ready, zero, 2'b00), "S_EXI");
                   finish(S_WBI, hb, rc, 1'($urandom)); end
      6'h23: begin
        rnd(); cyc(exp_for(S_MADDR, op, mem_ready, zero, 2'b00), "S_MADDR");
        do_wait(S_MRD, lm, 1'b0, 0, tr);
        if (tr) begin do_trap(2'b10); return; end
        finish(S_MWB, hb, rc, 1'($urandom));
      end
      6'h2B: begin
        rnd(); cyc(exp_for(S_MADDR, op, mem_ready, zero, 2'b00), "S_MADDR");
        do_wait(S_MWR, lm, hb, rc, tr);
        if (tr) begin do_trap(2'b10); return; end
      end
      6'h04: finish(S_BR, hb, rc, z);
      6'h02: finish(S_J, hb, rc, 1'($urandom));
      default: begin do_trap(2'b01); return; end
    endcase
    if (hb) begin
      for (int i = 0; i < nh; i++) begin
        rnd(); halt_req = 1'b1;
        cyc(exp_for(S_HALT, opcode, mem_ready, zero, 2'b00), "S_HALT");
      end
      rnd(); halt_req = 1'b0;
      cyc(exp_for(S_HALT, opcode, mem_ready, zero, 2'b00), "S_HALT_exit");
    end
  endtask

  function automatic int pick_lat();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
  endfunction

  logic [5:0] legal[8] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};

  initial begin
    bit tr;
    logic [5:0] op;
    @(posedge clk);
    #1;
    do_reset();
    run_instr(6'h00, 0, 0, 1'b0, -1);
    run_instr(6'h23, 0, 3, 1'b0, -1);
    run_instr(6'h2B, 0, 0, 1'b0, -1);
    run_instr(6'h04, 0, 0, 1'b1, -1);
    run_instr(6'h04, 0, 0, 1'b0, -1);
    run_instr(6'h02, 0, 0, 1'b0, -1);
    run_instr(6'h09, 0, 0, 1'b0, -1);
    run_instr(6'h3F, 0, 0, 1'b0, -1);
    run_instr(6'h00, 15, 0, 1'b0, -1);
    run_instr(6'h00, 16, 0, 1'b0, -1);
    run_instr(6'h2B, 0, 15, 1'b0, -1);
    run_instr(6'h23, 0, 16, 1'b0, -1);
    run_instr(6'h00, 0, 0, 1'b0, 2);
    run_instr(6'h00, 0, 0, 1'b0, 0);
    // reset arriving together with mem_ready in a store wait must win
    opcode = 6'($urandom);
    do_wait(S_FETCH, 0, 1'b0, 0, tr);
    opcode = 6'h2B; rnd();
    cyc(exp_for(S_DECODE, opcode, mem_ready, zero, 2'b00), "S_DECODE");
    rnd(); cyc(exp_for(S_MADDR, opcode, mem_ready, zero, 2'b00), "S_MADDR");
    repeat (2) begin
      mem_ready = 1'b0; zero = 1'($urandom); halt_req = 1'($urandom);
      cyc(exp_for(S_MWR, opcode, mem_ready, zero, 2'b00), "S_MWR");
    end
    mem_ready = 1'b1;
    do_reset();
    run_instr(6'h00, 0, 0, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do op = 6'($urandom); while (op inside {6'h00, 6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02});
      end else begin
        op = legal[$urandom_range(0, 7)];
      end
      run_instr(op, pick_lat(), pick_lat(), 1'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1);
    end
    checks++;
    if (ret_q.size() != 0) begin
      errors++;
      $display("FAIL retire_pending act=%0d required=0", ret_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout required=run completion");
    $fatal(1, "watchdog expired");
  end

endmodule
